// File: rtl/id_stage.sv
// Instruction-decode stage: control decode, bypassed register-file read,
// immediate sign-extension, branch target and the ID/EX pipeline register.
module id_stage #(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3,
  parameter int EXT_IN_WIDTH   = 6,
  parameter int EXT_OUT_WIDTH  = 8,
  parameter int PC_WIDTH       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              Instruction,
  input  logic [PC_WIDTH-1:0]      PC_in,
  input  logic                     flush,
  input  logic                     RegWriteBack,
  input  logic [REG_DIR_WIDTH-1:0] WriteReg,
  input  logic [REG_WIDTH-1:0]     WriteBack,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [REG_WIDTH-1:0]     readd1,
  output logic [REG_WIDTH-1:0]     readd2,
  output logic [REG_DIR_WIDTH-1:0] rs,
  output logic [REG_DIR_WIDTH-1:0] rt,
  output logic [REG_DIR_WIDTH-1:0] dest_reg,
  output logic                     ALUSrc,
  output logic                     MemtoReg,
  output logic                     MemWrite,
  output logic                     MemRead,
  output logic                     RegWrite,
  output logic                     Branch,
  output logic                     RegDst,
  output logic [1:0]               ALUop,
  output logic [EXT_OUT_WIDTH-1:0] SignExtendOut,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic                     illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [REG_WIDTH-1:0]     regs [REG_FILE_DEPTH];
  logic [REG_DIR_WIDTH-1:0] rs_a, rt_a, rd_a, dest_d;
  logic [REG_WIDTH-1:0]     rd1, rd2;
  logic                     byp1, byp2;
  logic [5:0]               opcode;
  logic                     d_alusrc, d_memtoreg, d_memwrite, d_memread;
  logic                     d_regwrite, d_branch, d_regdst, d_illegal, uses_rt;
  logic [1:0]               d_aluop;
  logic [EXT_OUT_WIDTH-1:0] sext;
  logic [PC_WIDTH-1:0]      bt;
  logic                     hazard, load;
  logic                     unused_instr;

  // Only the field/immediate bits are decoded; the rest is intentionally ignored.
  assign unused_instr = ^Instruction;

  assign opcode = Instruction[31:26];
  assign rs_a   = Instruction[20+REG_DIR_WIDTH:21];
  assign rt_a   = Instruction[15+REG_DIR_WIDTH:16];
  assign rd_a   = Instruction[10+REG_DIR_WIDTH:11];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) regs[i] <= '0;
    end else if (RegWriteBack && (WriteReg != '0)) begin
      regs[WriteReg] <= WriteBack;
    end
  end

  // Write-before-read: a same-cycle write-back is forwarded to the read ports.
  assign byp1 = RegWriteBack && (WriteReg != '0) && (WriteReg == rs_a);
  assign byp2 = RegWriteBack && (WriteReg != '0) && (WriteReg == rt_a);
  assign rd1  = (rs_a == '0) ? '0 : (byp1 ? WriteBack : regs[rs_a]);
  assign rd2  = (rt_a == '0) ? '0 : (byp2 ? WriteBack : regs[rt_a]);

  always_comb begin
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_memwrite = 1'b0;
    d_memread  = 1'b0;
    d_regwrite = 1'b0;
    d_branch   = 1'b0;
    d_regdst   = 1'b0;
    d_aluop    = 2'b00;
    d_illegal  = 1'b0;
    uses_rt    = 1'b0;
    case (opcode)
      OP_R:    begin d_regwrite = 1'b1; d_regdst = 1'b1; d_aluop = 2'b10; uses_rt = 1'b1; end
      OP_LW:   begin d_alusrc = 1'b1; d_memtoreg = 1'b1; d_memread = 1'b1; d_regwrite = 1'b1; end
      OP_SW:   begin d_alusrc = 1'b1; d_memwrite = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:  begin d_branch = 1'b1; d_aluop = 2'b01; uses_rt = 1'b1; end
      OP_ADDI: begin d_alusrc = 1'b1; d_regwrite = 1'b1; end
      default: d_illegal = 1'b1;
    endcase
  end

  assign dest_d = d_regdst ? rd_a : rt_a;
  assign sext   = EXT_OUT_WIDTH'($signed(Instruction[EXT_IN_WIDTH-1:0]));
  assign bt     = PC_in + PC_WIDTH'(1) + PC_WIDTH'($signed(sext));

  // Load-use check against the instruction currently held in ID/EX.
  assign hazard = in_valid && ex_valid && MemRead && (dest_reg != '0) &&
                  ((dest_reg == rs_a) || ((dest_reg == rt_a) && uses_rt));
  assign stall  = hazard && !flush;
  assign load   = in_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (rst || !load) begin
      ex_valid      <= 1'b0;
      readd1        <= '0;
      readd2        <= '0;
      rs            <= '0;
      rt            <= '0;
      dest_reg      <= '0;
      ALUSrc        <= 1'b0;
      MemtoReg      <= 1'b0;
      MemWrite      <= 1'b0;
      MemRead       <= 1'b0;
      RegWrite      <= 1'b0;
      Branch        <= 1'b0;
      RegDst        <= 1'b0;
      ALUop         <= 2'b00;
      SignExtendOut <= '0;
      branch_target <= '0;
      illegal       <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      readd1        <= rd1;
      readd2        <= rd2;
      rs            <= rs_a;
      rt            <= rt_a;
      dest_reg      <= dest_d;
      ALUSrc        <= d_alusrc;
      MemtoReg      <= d_memtoreg;
      MemWrite      <= d_memwrite;
      MemRead       <= d_memread;
      RegWrite      <= d_regwrite;
      Branch        <= d_branch;
      RegDst        <= d_regdst;
      ALUop         <= d_aluop;
      SignExtendOut <= sext;
      branch_target <= bt;
      illegal       <= d_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued at issue
// time and compared by a monitor whenever ex_valid is presented.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] Instruction;
  logic [5:0]  PC_in;
  logic        flush;
  logic        RegWriteBack;
  logic [2:0]  WriteReg;
  logic [7:0]  WriteBack;
  logic        stall, ex_valid;
  logic [7:0]  readd1, readd2;
  logic [2:0]  rs, rt, dest_reg;
  logic        ALUSrc, MemtoReg, MemWrite, MemRead, RegWrite, Branch, RegDst;
  logic [1:0]  ALUop;
  logic [7:0]  SignExtendOut;
  logic [5:0]  branch_target;
  logic        illegal;

  int checks = 0;
  int passes = 0;
  logic [48:0] expq[$];

  localparam logic [6:0] C_R    = 7'b0000101;
  localparam logic [6:0] C_LW   = 7'b1101100;
  localparam logic [6:0] C_SW   = 7'b1010000;
  localparam logic [6:0] C_BEQ  = 7'b0000010;
  localparam logic [6:0] C_ADDI = 7'b1000100;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Instruction(Instruction),
    .PC_in(PC_in), .flush(flush), .RegWriteBack(RegWriteBack),
    .WriteReg(WriteReg), .WriteBack(WriteBack), .stall(stall),
    .ex_valid(ex_valid), .readd1(readd1), .readd2(readd2), .rs(rs), .rt(rt),
    .dest_reg(dest_reg), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite),
    .Branch(Branch), .RegDst(RegDst), .ALUop(ALUop),
    .SignExtendOut(SignExtendOut), .branch_target(branch_target),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] pk(input logic [7:0] r1, input logic [7:0] r2,
                                     input logic [2:0] s, input logic [2:0] t,
                                     input logic [2:0] d, input logic [6:0] c,
                                     input logic [1:0] op, input logic [7:0] se,
                                     input logic [5:0] b, input logic il);
    return {r1, r2, s, t, d, c, op, se, b, il};
  endfunction

  function automatic logic [48:0] dut_pk();
    return pk(readd1, readd2, rs, rt, dest_reg,
              {ALUSrc, MemtoReg, MemWrite, MemRead, RegWrite, Branch, RegDst},
              ALUop, SignExtendOut, branch_target, illegal);
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic chk(input string name, input logic [48:0] act, input logic [48:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one cycle, then drive this cycle's inputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [5:0] pc,
                      input logic fl, input logic wb, input logic [2:0] wr,
                      input logic [7:0] wd);
    @(posedge clk);
    #1;
    in_valid = v; Instruction = ins; PC_in = pc; flush = fl;
    RegWriteBack = wb; WriteReg = wr; WriteBack = wd;
    #1;
  endtask

  always @(negedge clk) begin
    if (ex_valid) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: got %h expected nothing", dut_pk());
      end else begin
        chk("idex_contents", dut_pk(), expq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; Instruction = '0; PC_in = '0; flush = 1'b0;
    RegWriteBack = 1'b0; WriteReg = '0; WriteBack = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", dut_pk(), '0);
    chk("reset_ex_valid", {48'd0, ex_valid}, '0);
    chk("reset_stall", {48'd0, stall}, '0);
    rst = 1'b0;

    step(0, '0, 6'h00, 0, 1, 3'd3, 8'h5A);                 // r3 = 0x5A
    step(1, mk_r(3, 1, 5), 6'h10, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h5A, 8'h00, 3, 1, 5, C_R, 2'b10, 8'h00, 6'h11, 0));
    step(1, mk_r(2, 3, 6), 6'h11, 0, 1, 3'd2, 8'h33);      // same-cycle bypass
    expq.push_back(pk(8'h33, 8'h5A, 2, 3, 6, C_R, 2'b10, 8'h00, 6'h12, 0));
    step(1, mk_r(0, 2, 7), 6'h12, 0, 1, 3'd0, 8'hFF);      // write to r0 ignored
    expq.push_back(pk(8'h00, 8'h33, 0, 2, 7, C_R, 2'b10, 8'h00, 6'h13, 0));
    step(1, mk_i(6'b100011, 2, 4, 16'h0001), 6'h13, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h33, 8'h00, 2, 4, 4, C_LW, 2'b00, 8'h01, 6'h15, 0));

    step(1, mk_r(4, 1, 5), 6'h14, 0, 1, 3'd4, 8'h77);      // load-use on rs
    chk("loaduse_stall", {48'd0, stall}, 49'd1);
    step(1, mk_r(4, 1, 5), 6'h14, 0, 0, 3'd0, 8'h00);
    chk("bubble_ex_valid", {48'd0, ex_valid}, '0);
    chk("bubble_memread", {48'd0, MemRead}, '0);
    chk("stall_released", {48'd0, stall}, '0);
    expq.push_back(pk(8'h77, 8'h00, 4, 1, 5, C_R, 2'b10, 8'h00, 6'h15, 0));

    step(1, mk_i(6'b100011, 0, 4, 16'h0002), 6'h20, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h00, 8'h77, 0, 4, 4, C_LW, 2'b00, 8'h02, 6'h23, 0));
    step(1, mk_i(6'b001000, 1, 4, 16'h0003), 6'h21, 0, 0, 3'd0, 8'h00);
    chk("addi_rt_no_stall", {48'd0, stall}, '0);
    expq.push_back(pk(8'h00, 8'h77, 1, 4, 4, C_ADDI, 2'b00, 8'h03, 6'h25, 0));

    step(1, mk_i(6'b000100, 2, 3, 16'h003E), 6'h3F, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h33, 8'h5A, 2, 3, 3, C_BEQ, 2'b01, 8'hFE, 6'h3E, 0));

    step(1, mk_i(6'b100011, 1, 2, 16'h0000), 6'h01, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h00, 8'h33, 1, 2, 2, C_LW, 2'b00, 8'h00, 6'h02, 0));
    step(1, mk_i(6'b101011, 0, 2, 16'h0000), 6'h02, 1, 0, 3'd0, 8'h00);
    chk("flush_beats_stall", {48'd0, stall}, '0);
    step(0, '0, 6'h00, 0, 0, 3'd0, 8'h00);
    chk("flush_bubble", {48'd0, ex_valid}, '0);

    step(1, {6'b111111, 5'd1, 5'd2, 16'h0000}, 6'h05, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h00, 8'h33, 1, 2, 2, 7'd0, 2'b00, 8'h00, 6'h06, 1));

    step(1, mk_r(1, 2, 3), 6'h07, 0, 1, 3'd1, 8'h99);
    rst = 1'b1;                                              // write-back dropped
    step(1, mk_r(1, 2, 3), 6'h00, 0, 0, 3'd0, 8'h00);
    rst = 1'b0;
    chk("rst_outputs", dut_pk(), '0);
    chk("rst_ex_valid", {48'd0, ex_valid}, '0);
    expq.push_back(pk(8'h00, 8'h00, 1, 2, 3, C_R, 2'b10, 8'h00, 6'h01, 0));

    step(1, mk_i(6'b100011, 0, 4, 16'h0000), 6'h08, 0, 0, 3'd0, 8'h00);
    expq.push_back(pk(8'h00, 8'h00, 0, 4, 4, C_LW, 2'b00, 8'h00, 6'h09, 0));
    step(1, mk_r(4, 1, 5), 6'h09, 0, 0, 3'd0, 8'h00);
    chk("stall_before_rst", {48'd0, stall}, 49'd1);
    rst = 1'b1;
    step(1, mk_r(4, 1, 5), 6'h09, 0, 0, 3'd0, 8'h00);
    rst = 1'b0;
    chk("rst_mid_stall_ex_valid", {48'd0, ex_valid}, '0);
    chk("rst_mid_stall_stall", {48'd0, stall}, '0);
    expq.push_back(pk(8'h00, 8'h00, 4, 1, 5, C_R, 2'b10, 8'h00, 6'h0A, 0));

    step(0, '0, 6'h00, 0, 0, 3'd0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 49'(expq.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
